// File: rtl/pulse_measure.sv
// Pulse width / period meter on the de-glitched feedback level. Completed
// measurements leave through a one-entry valid/ready result register.
module pulse_measure #(
  parameter int _RAM_WIDTH = 32
) (
  input  logic                  io_clk,
  input  logic                  io_rst,
  input  logic                  io_enable,
  input  logic                  io_fb_catch,
  input  logic                  io_defaultLevel,
  input  logic [_RAM_WIDTH-1:0] io_timeout,
  input  logic                  io_ready,
  input  logic                  io_clrFlags,
  output logic                  io_valid,
  output logic [_RAM_WIDTH-1:0] io_width,
  output logic [_RAM_WIDTH-1:0] io_period,
  output logic                  io_overrun,
  output logic                  io_stall
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [_RAM_WIDTH-1:0] CNT_ZERO = {_RAM_WIDTH{1'b0}};
  localparam logic [_RAM_WIDTH-1:0] CNT_ONE  = {{(_RAM_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state_r;
  logic                    prev_r;
  logic                    dfl_r;
  logic [_RAM_WIDTH-1:0]   width_cnt_r;
  logic [_RAM_WIDTH-1:0]   period_cnt_r;

  logic act_s;
  logic prev_act_s;
  logic lead_s;
  logic trail_s;
  logic dfl_change_s;
  logic run_s;
  logic timeout_hit_s;
  logic emit_s;
  logic stall_set_s;
  logic overrun_set_s;

  // Counters stick at all-ones instead of wrapping to a bogus small value.
  function automatic logic [_RAM_WIDTH-1:0] sat_inc(input logic [_RAM_WIDTH-1:0] value);
    logic [_RAM_WIDTH-1:0] result;
    if (&value) begin
      result = value;
    end else begin
      result = value + CNT_ONE;
    end
    return result;
  endfunction

  // Edge decode relative to the idle level and qualification of emit/stall events
  always_comb begin
    act_s         = (io_fb_catch != io_defaultLevel);
    prev_act_s    = (prev_r != io_defaultLevel);
    lead_s        = act_s & ~prev_act_s;
    trail_s       = ~act_s & prev_act_s;
    dfl_change_s  = (io_defaultLevel != dfl_r);
    run_s         = io_enable & ~dfl_change_s;
    timeout_hit_s = (io_timeout != CNT_ZERO) && (period_cnt_r == io_timeout);
    emit_s        = 1'b0;
    stall_set_s   = 1'b0;
    case (state_r)
      HIGH: begin
        emit_s      = 1'b0;
        stall_set_s = run_s & timeout_hit_s;
      end
      LOW: begin
        emit_s      = run_s & lead_s;
        stall_set_s = run_s & ~lead_s & timeout_hit_s;
      end
      default: begin
        emit_s      = 1'b0;
        stall_set_s = 1'b0;
      end
    endcase
    overrun_set_s = emit_s & io_valid & ~io_ready;
  end

  // Measurement FSM, counters and the registered result/flag outputs
  always_ff @(posedge io_clk or posedge io_rst) begin
    if (io_rst) begin
      state_r      <= IDLE;
      prev_r       <= 1'b0;
      dfl_r        <= 1'b0;
      width_cnt_r  <= CNT_ZERO;
      period_cnt_r <= CNT_ZERO;
      io_valid     <= 1'b0;
      io_width     <= CNT_ZERO;
      io_period    <= CNT_ZERO;
      io_overrun   <= 1'b0;
      io_stall     <= 1'b0;
    end else begin
      prev_r <= io_fb_catch;
      dfl_r  <= io_defaultLevel;

      // A disable or a change of idle level abandons the measurement in flight.
      if (!run_s) begin
        state_r      <= IDLE;
        width_cnt_r  <= CNT_ZERO;
        period_cnt_r <= CNT_ZERO;
      end else begin
        case (state_r)
          IDLE: begin
            if (lead_s) begin
              state_r      <= HIGH;
              width_cnt_r  <= CNT_ONE;
              period_cnt_r <= CNT_ONE;
            end else begin
              width_cnt_r  <= CNT_ZERO;
              period_cnt_r <= CNT_ZERO;
            end
          end
          HIGH: begin
            if (stall_set_s) begin
              state_r      <= IDLE;
              width_cnt_r  <= CNT_ZERO;
              period_cnt_r <= CNT_ZERO;
            end else begin
              period_cnt_r <= sat_inc(period_cnt_r);
              if (trail_s) begin
                state_r <= LOW;
              end else if (act_s) begin
                width_cnt_r <= sat_inc(width_cnt_r);
              end
            end
          end
          LOW: begin
            if (emit_s) begin
              state_r      <= HIGH;
              width_cnt_r  <= CNT_ONE;
              period_cnt_r <= CNT_ONE;
            end else if (stall_set_s) begin
              state_r      <= IDLE;
              width_cnt_r  <= CNT_ZERO;
              period_cnt_r <= CNT_ZERO;
            end else begin
              period_cnt_r <= sat_inc(period_cnt_r);
            end
          end
          default: begin
            state_r      <= IDLE;
            width_cnt_r  <= CNT_ZERO;
            period_cnt_r <= CNT_ZERO;
          end
        endcase
      end

      // A full, unread register keeps its old data; the new result is dropped.
      if (emit_s && !overrun_set_s) begin
        io_valid  <= 1'b1;
        io_width  <= width_cnt_r;
        io_period <= period_cnt_r;
      end else if (!emit_s && io_valid && io_ready) begin
        io_valid <= 1'b0;
      end

      if (overrun_set_s) begin
        io_overrun <= 1'b1;
      end else if (io_clrFlags) begin
        io_overrun <= 1'b0;
      end

      if (stall_set_s) begin
        io_stall <= 1'b1;
      end else if (io_clrFlags) begin
        io_stall <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pulse_measure.sv
// Bench for pulse_measure: pattern table, directed corner sequences and a
// randomized run, all checked against a timestamp-based reference model.
module tb_pulse_measure;
  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         en;
  logic         fb;
  logic         dfl;
  logic         ready;
  logic         clr;
  logic [W-1:0] tmo;
  logic         valid;
  logic [W-1:0] width;
  logic [W-1:0] period;
  logic         overrun;
  logic         stall;

  int checks = 0;
  int errors = 0;

  // Reference model: remembers when the last leading edge happened and how
  // many active samples followed it; period is simply elapsed time.
  bit           m_prev, m_dflr, m_armed, m_valid, m_ovr, m_stall;
  longint       m_now, m_lead_t, m_act;
  logic [W-1:0] m_w, m_p;

  int           obs_n;
  bit           obs_chk;
  logic [W-1:0] exp_w, exp_p;

  typedef struct {
    bit dfl;
    int act_len;
    int idle_len;
    int reps;
    int exp_n;
    int exp_w;
    int exp_p;
  } vec_t;
  vec_t vecs [4];

  pulse_measure #(._RAM_WIDTH(W)) dut (
    .io_clk          (clk),
    .io_rst          (rst),
    .io_enable       (en),
    .io_fb_catch     (fb),
    .io_defaultLevel (dfl),
    .io_timeout      (tmo),
    .io_ready        (ready),
    .io_clrFlags     (clr),
    .io_valid        (valid),
    .io_width        (width),
    .io_period       (period),
    .io_overrun      (overrun),
    .io_stall        (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b0; m_dflr = 1'b0; m_armed = 1'b0;
    m_valid = 1'b0; m_ovr = 1'b0; m_stall = 1'b0;
    m_now = 0; m_lead_t = 0; m_act = 0;
    m_w = '0; m_p = '0;
  endtask

  task automatic model_eval();
    bit a, pa, ld, emit, oset, sset;
    logic [W-1:0] ew, ep;
    a = (fb != dfl);
    pa = (m_prev != dfl);
    ld = a && !pa;
    emit = 1'b0; sset = 1'b0; ew = '0; ep = '0;
    if (!en || (dfl != m_dflr)) begin
      m_armed = 1'b0;
    end else if (ld) begin
      if (m_armed) begin
        emit = 1'b1;
        ew = W'(m_act);
        ep = W'(m_now - m_lead_t);
      end
      m_armed = 1'b1;
      m_lead_t = m_now;
      m_act = 1;
    end else if (m_armed) begin
      if ((tmo != '0) && ((m_now - m_lead_t) == longint'(tmo))) begin
        sset = 1'b1;
        m_armed = 1'b0;
      end else if (a) begin
        m_act++;
      end
    end
    oset = emit && m_valid && !ready;
    if (emit && !oset) begin
      m_valid = 1'b1; m_w = ew; m_p = ep;
    end else if (!emit && m_valid && ready) begin
      m_valid = 1'b0;
    end
    if (oset) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
    if (sset) m_stall = 1'b1;
    else if (clr) m_stall = 1'b0;
    m_prev = fb;
    m_dflr = dfl;
    m_now++;
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
    check("mdl_valid", 64'(valid), 64'(m_valid));
    check("mdl_overrun", 64'(overrun), 64'(m_ovr));
    check("mdl_stall", 64'(stall), 64'(m_stall));
    if (m_valid) begin
      check("mdl_width", 64'(width), 64'(m_w));
      check("mdl_period", 64'(period), 64'(m_p));
    end
    if (valid) begin
      obs_n++;
      if (obs_chk) begin
        check("res_width", 64'(width), 64'(exp_w));
        check("res_period", 64'(period), 64'(exp_p));
      end
    end
  endtask

  task automatic run_level(input bit lvl, input int n);
    fb = lvl;
    repeat (n) step();
  endtask

  task automatic idle_fsm(input bit d, input int n);
    en = 1'b0; dfl = d; fb = d; clr = 1'b0; ready = 1'b1;
    repeat (n) step();
    en = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; fb = 1'b0; dfl = 1'b0;
    ready = 1'b1; clr = 1'b0; tmo = '0;
    obs_n = 0; obs_chk = 1'b0; exp_w = '0; exp_p = '0;
    model_reset();

    vecs[0] = '{dfl: 1'b0, act_len: 5, idle_len: 15, reps: 3, exp_n: 2, exp_w: 5, exp_p: 20};
    vecs[1] = '{dfl: 1'b1, act_len: 3, idle_len: 7,  reps: 3, exp_n: 2, exp_w: 3, exp_p: 10};
    vecs[2] = '{dfl: 1'b0, act_len: 1, idle_len: 1,  reps: 4, exp_n: 3, exp_w: 1, exp_p: 2};
    vecs[3] = '{dfl: 1'b0, act_len: 8, idle_len: 2,  reps: 3, exp_n: 2, exp_w: 8, exp_p: 10};

    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 64'(valid), 64'd0);
    check("reset_width", 64'(width), 64'd0);
    check("reset_period", 64'(period), 64'd0);
    check("reset_overrun", 64'(overrun), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    rst = 1'b0;

    // Pattern table: free-running pulse trains with ready held high
    for (int i = 0; i < 4; i++) begin
      idle_fsm(vecs[i].dfl, 3);
      obs_n = 0;
      obs_chk = 1'b1;
      exp_w = W'(vecs[i].exp_w);
      exp_p = W'(vecs[i].exp_p);
      for (int r = 0; r < vecs[i].reps; r++) begin
        run_level(!vecs[i].dfl, vecs[i].act_len);
        run_level(vecs[i].dfl, vecs[i].idle_len);
      end
      check("vec_result_count", 64'(obs_n), 64'(vecs[i].exp_n));
      obs_chk = 1'b0;
    end

    // Back-pressure, overrun, set-beats-clear, drain, clear
    idle_fsm(1'b0, 3);
    ready = 1'b0;
    repeat (3) begin
      run_level(1'b1, 4);
      run_level(1'b0, 6);
    end
    check("bp_valid", 64'(valid), 64'd1);
    check("bp_width", 64'(width), 64'd4);
    check("bp_period", 64'(period), 64'd10);
    check("bp_overrun", 64'(overrun), 64'd1);
    fb = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0;
    check("bp_set_wins", 64'(overrun), 64'd1);
    check("bp_held_width", 64'(width), 64'd4);
    run_level(1'b1, 2);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("bp_drain", 64'(valid), 64'd0);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("bp_clear", 64'(overrun), 64'd0);
    run_level(1'b0, 3);

    // Timeout: one pulse then silence
    idle_fsm(1'b0, 3);
    tmo = 32'd50;
    obs_n = 0;
    fb = 1'b1;
    step();
    for (int k = 1; k <= 60; k++) begin
      fb = (k < 5);
      step();
      if (k == 49) check("to_stall_early", 64'(stall), 64'd0);
      if (k == 50) check("to_stall", 64'(stall), 64'd1);
    end
    check("to_no_valid", 64'(obs_n), 64'd0);
    tmo = '0;
    obs_n = 0; obs_chk = 1'b1; exp_w = 32'd2; exp_p = 32'd6;
    run_level(1'b1, 2); run_level(1'b0, 4);
    run_level(1'b1, 2); run_level(1'b0, 2);
    check("to_rearm_count", 64'(obs_n), 64'd1);
    check("to_stall_sticky", 64'(stall), 64'd1);
    obs_chk = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("to_stall_clear", 64'(stall), 64'd0);

    // Disturbance: enable drop mid-pulse, idle-level toggle mid-period
    idle_fsm(1'b0, 3);
    obs_n = 0; obs_chk = 1'b1; exp_w = 32'd3; exp_p = 32'd8;
    run_level(1'b1, 2);
    en = 1'b0; step(); en = 1'b1;
    run_level(1'b1, 2); run_level(1'b0, 5);
    run_level(1'b1, 3); run_level(1'b0, 2);
    dfl = 1'b1; step(); dfl = 1'b0; step();
    run_level(1'b0, 3);
    run_level(1'b1, 3); run_level(1'b0, 5);
    run_level(1'b1, 3); run_level(1'b0, 2);
    check("dist_result_count", 64'(obs_n), 64'd1);
    obs_chk = 1'b0;

    // Asynchronous reset while a result and the overrun flag are held
    idle_fsm(1'b0, 3);
    ready = 1'b0;
    repeat (3) begin
      run_level(1'b1, 2);
      run_level(1'b0, 3);
    end
    check("rs_pre_valid", 64'(valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rs_valid", 64'(valid), 64'd0);
    check("rs_width", 64'(width), 64'd0);
    check("rs_period", 64'(period), 64'd0);
    check("rs_overrun", 64'(overrun), 64'd0);
    check("rs_stall", 64'(stall), 64'd0);
    model_reset();
    fb = 1'b0; dfl = 1'b0; en = 1'b1; ready = 1'b1; clr = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized run against the reference model, without and with timeout
    for (int ph = 0; ph < 2; ph++) begin
      tmo = (ph == 0) ? 32'd0 : 32'd20;
      en = 1'b1;
      for (int s = 0; s < 150; s++) begin
        int len;
        len = int'($urandom_range(1, 12));
        fb = 1'($urandom_range(0, 1));
        for (int c = 0; c < len; c++) begin
          ready = ($urandom_range(0, 3) != 0);
          clr = ($urandom_range(0, 39) == 0);
          en = ($urandom_range(0, 199) != 0);
          if ($urandom_range(0, 299) == 0) dfl = ~dfl;
          step();
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
